vga_rect_fill: RTL and testbench

Hardware rectangle-fill engine and Avalon-MM write initiator for the SRAM frame buffer's source port. It accepts one rectangle command at a time and clips it to the display. It then writes the fill colour to every pixel in raster order, using the frame buffer's linear address map (address = y*H_DISPLAY + x) and honouring `avn_waitrequest`. It sits between the pixel-generation logic (CPU/registers) and the frame buffer source interface.

---
 rtl/vga_rect_fill.sv | 188 ++++++++++++++++++
 tb/tb_vga_rect_fill.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: clips a command to the display and writes the fill
// colour to every covered pixel in raster order over an Avalon-MM write port.
module vga_rect_fill #(
    parameter int unsigned AVN_AW    = 18,
    parameter int unsigned AVN_DW    = 16,
    parameter int unsigned RGB_SIZE  = 12,
    parameter int unsigned H_SIZE    = 10,
    parameter int unsigned V_SIZE    = 10,
    parameter int unsigned H_DISPLAY = 320,
    parameter int unsigned V_DISPLAY = 240
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [H_SIZE-1:0]   cmd_x0,
    input  logic [H_SIZE-1:0]   cmd_x1,
    input  logic [V_SIZE-1:0]   cmd_y0,
    input  logic [V_SIZE-1:0]   cmd_y1,
    input  logic [RGB_SIZE-1:0] cmd_rgb,
    input  logic                cmd_abort,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic                avn_read,
    output logic                avn_write,
    output logic [AVN_AW-1:0]   avn_address,
    output logic [AVN_DW-1:0]   avn_writedata,
    input  logic                avn_waitrequest
);

    localparam logic [H_SIZE-1:0] LP_X_MAX  = H_SIZE'(H_DISPLAY - 1);
    localparam logic [V_SIZE-1:0] LP_Y_MAX  = V_SIZE'(V_DISPLAY - 1);
    localparam logic [AVN_AW-1:0] LP_H_STEP = AVN_AW'(H_DISPLAY);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [H_SIZE-1:0]   r_x;
    logic [V_SIZE-1:0]   r_y;
    logic [H_SIZE-1:0]   r_x0;
    logic [H_SIZE-1:0]   r_x1c;
    logic [V_SIZE-1:0]   r_y1c;
    logic [AVN_AW-1:0]   r_row_base;
    logic                r_abort;

    logic [H_SIZE-1:0]   w_x_nxt;
    logic [V_SIZE-1:0]   w_y_nxt;
    logic [AVN_AW-1:0]   w_row_base_nxt;
    logic                w_abort_nxt;
    logic                w_err_nxt;

    logic                w_accept;
    logic                w_beat;
    logic [H_SIZE-1:0]   w_x1c_in;
    logic [V_SIZE-1:0]   w_y1c_in;
    logic                w_empty;

    logic                r_cmd_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_avn_write;
    logic [AVN_AW-1:0]   r_avn_address;
    logic [AVN_DW-1:0]   r_avn_writedata;

    // Clip incoming bounds and classify the command before it is accepted
    always_comb begin
        w_x1c_in = (cmd_x1 > LP_X_MAX) ? LP_X_MAX : cmd_x1;
        w_y1c_in = (cmd_y1 > LP_Y_MAX) ? LP_Y_MAX : cmd_y1;
        w_empty  = (cmd_x0 > w_x1c_in) | (cmd_y0 > w_y1c_in) |
                   (cmd_x0 > LP_X_MAX) | (cmd_y0 > LP_Y_MAX);
        w_accept = cmd_valid & (r_state == S_IDLE);
        w_beat   = (r_state == S_WRITE) & ~avn_waitrequest;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and raster-walk logic
    always_comb begin
        w_state_nxt    = r_state;
        w_x_nxt        = r_x;
        w_y_nxt        = r_y;
        w_row_base_nxt = r_row_base;
        w_abort_nxt    = r_abort;
        w_err_nxt      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_abort_nxt = 1'b0;
                if (w_accept) begin
                    w_x_nxt        = cmd_x0;
                    w_y_nxt        = cmd_y0;
                    w_row_base_nxt = AVN_AW'(cmd_y0) * LP_H_STEP;
                    if (w_empty) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                w_abort_nxt = r_abort | cmd_abort;
                if (w_beat) begin
                    if (w_abort_nxt) begin
                        w_state_nxt = S_DONE;
                        w_err_nxt   = 1'b1;
                    end else if (r_x != r_x1c) begin
                        w_x_nxt = r_x + H_SIZE'(1);
                    end else if (r_y != r_y1c) begin
                        w_x_nxt        = r_x0;
                        w_y_nxt        = r_y + V_SIZE'(1);
                        w_row_base_nxt = r_row_base + LP_H_STEP;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_abort_nxt = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs; address only moves on accept or beat
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_x             <= '0;
            r_y             <= '0;
            r_x0            <= '0;
            r_x1c           <= '0;
            r_y1c           <= '0;
            r_row_base      <= '0;
            r_abort         <= 1'b0;
            r_cmd_ready     <= 1'b1;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_err           <= 1'b0;
            r_avn_write     <= 1'b0;
            r_avn_address   <= '0;
            r_avn_writedata <= '0;
        end else begin
            r_x           <= w_x_nxt;
            r_y           <= w_y_nxt;
            r_row_base    <= w_row_base_nxt;
            r_abort       <= w_abort_nxt;
            r_cmd_ready   <= (w_state_nxt == S_IDLE);
            r_busy        <= (w_state_nxt == S_WRITE);
            r_avn_write   <= (w_state_nxt == S_WRITE);
            r_done        <= (w_state_nxt == S_DONE);
            r_err         <= w_err_nxt;
            r_avn_address <= w_row_base_nxt + AVN_AW'(w_x_nxt);
            if (w_accept) begin
                r_x0            <= cmd_x0;
                r_x1c           <= w_x1c_in;
                r_y1c           <= w_y1c_in;
                r_avn_writedata <= AVN_DW'(cmd_rgb);
            end
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign avn_read      = 1'b0;
    assign avn_write     = r_avn_write;
    assign avn_address   = r_avn_address;
    assign avn_writedata = r_avn_writedata;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: beat log, stall/abort injection and
// hand-computed addresses, data and done/err timing.
module tb_vga_rect_fill;

    logic        sys_clk;
    logic        sys_rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_x0, cmd_x1;
    logic [9:0]  cmd_y0, cmd_y1;
    logic [11:0] cmd_rgb;
    logic        cmd_abort;
    logic        busy, done, err;
    logic        avn_read, avn_write;
    logic [17:0] avn_address;
    logic [15:0] avn_writedata;
    logic        avn_waitrequest;

    int n_cmp;
    int n_mis;

    int cyc, acc_cyc, done_cyc, done_cnt;
    bit acc_seen, done_err;
    int stall_from, stall_len, abort_at;
    bit abort_en;
    int hold_viol, stall_seen;
    bit prev_stall;
    logic [17:0] prev_addr;
    logic [15:0] prev_data;
    logic [17:0] beats[$];
    logic [15:0] datas[$];

    vga_rect_fill dut (
        .sys_clk         (sys_clk),
        .sys_rst_n       (sys_rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_x0          (cmd_x0),
        .cmd_x1          (cmd_x1),
        .cmd_y0          (cmd_y0),
        .cmd_y1          (cmd_y1),
        .cmd_rgb         (cmd_rgb),
        .cmd_abort       (cmd_abort),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .avn_read        (avn_read),
        .avn_write       (avn_write),
        .avn_address     (avn_address),
        .avn_writedata   (avn_writedata),
        .avn_waitrequest (avn_waitrequest)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Edge monitor: logs beats, stall holds and done pulses, then drives
    // waitrequest/abort for the next edge relative to the accept edge.
    always @(posedge sys_clk) begin
        cyc = cyc + 1;
        if (cmd_valid && cmd_ready) begin
            acc_cyc  = cyc;
            acc_seen = 1'b1;
        end
        if (avn_write && !avn_waitrequest) begin
            beats.push_back(avn_address);
            datas.push_back(avn_writedata);
        end
        if (prev_stall && avn_write &&
            (avn_address !== prev_addr || avn_writedata !== prev_data))
            hold_viol++;
        if (avn_write && avn_waitrequest) stall_seen++;
        prev_stall = avn_write && avn_waitrequest;
        prev_addr  = avn_address;
        prev_data  = avn_writedata;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            done_err = err;
        end
        #1;
        avn_waitrequest = acc_seen && (cyc + 1 - acc_cyc >= stall_from) &&
                          (cyc + 1 - acc_cyc < stall_from + stall_len);
        cmd_abort = acc_seen && abort_en && (cyc + 1 - acc_cyc == abort_at);
    end

    task automatic start_cmd(input logic [9:0] x0, input logic [9:0] x1,
                             input logic [9:0] y0, input logic [9:0] y1,
                             input logic [11:0] rgb);
        beats.delete();
        datas.delete();
        done_cnt   = 0;
        hold_viol  = 0;
        stall_seen = 0;
        cmd_x0 = x0; cmd_x1 = x1; cmd_y0 = y0; cmd_y1 = y1; cmd_rgb = rgb;
        cmd_valid = 1'b1;
        @(posedge sys_clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            @(posedge sys_clk); #1;
            n++;
        end
        chk(tag, done_cnt, 1);
        acc_seen   = 1'b0;
        stall_len  = 0;
        abort_en   = 1'b0;
    endtask

    initial begin
        int bad;
        n_cmp = 0; n_mis = 0;
        cyc = 0; acc_cyc = 0; done_cyc = 0; done_cnt = 0;
        acc_seen = 0; done_err = 0;
        stall_from = 0; stall_len = 0; abort_at = 0; abort_en = 0;
        hold_viol = 0; stall_seen = 0; prev_stall = 0;
        prev_addr = '0; prev_data = '0;
        cmd_valid = 0; cmd_abort = 0; avn_waitrequest = 0;
        cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_rgb = '0;
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_write",     avn_write, 0);
        chk("rst_read",      avn_read, 0);
        chk("rst_busy",      busy, 0);
        chk("rst_done",      done, 0);
        chk("rst_err",       err, 0);
        chk("rst_addr",      avn_address, 0);
        chk("rst_data",      avn_writedata, 0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // single pixel
        start_cmd(10'd5, 10'd5, 10'd3, 10'd3, 12'hF0A);
        wait_done("px_done", 20);
        chk("px_count", beats.size(), 1);
        if (beats.size() == 1) begin
            chk("px_addr", beats[0], 965);
            chk("px_data", datas[0], 16'h0F0A);
        end
        chk("px_done_cyc", done_cyc - acc_cyc, 2);
        chk("px_err", done_err, 0);

        // x clipping across two rows
        start_cmd(10'd318, 10'd330, 10'd0, 10'd1, 12'h123);
        wait_done("clip_done", 20);
        chk("clip_count", beats.size(), 4);
        if (beats.size() == 4) begin
            chk("clip_a0", beats[0], 318);
            chk("clip_a1", beats[1], 319);
            chk("clip_a2", beats[2], 638);
            chk("clip_a3", beats[3], 639);
        end
        chk("clip_done_cyc", done_cyc - acc_cyc, 5);
        chk("clip_err", done_err, 0);

        // 4-cycle stall on the second beat
        stall_from = 2; stall_len = 4;
        start_cmd(10'd0, 10'd2, 10'd0, 10'd0, 12'hABC);
        wait_done("stall_done", 30);
        chk("stall_count", beats.size(), 3);
        if (beats.size() == 3) begin
            chk("stall_a0", beats[0], 0);
            chk("stall_a1", beats[1], 1);
            chk("stall_a2", beats[2], 2);
            chk("stall_d1", datas[1], 16'h0ABC);
        end
        chk("stall_hold", hold_viol, 0);
        chk("stall_cycles", stall_seen, 4);
        chk("stall_done_cyc", done_cyc - acc_cyc, 8);

        // empty command
        start_cmd(10'd10, 10'd4, 10'd0, 10'd0, 12'h555);
        wait_done("empty_done", 10);
        chk("empty_count", beats.size(), 0);
        chk("empty_done_cyc", done_cyc - acc_cyc, 1);
        chk("empty_err", done_err, 1);

        // full screen
        start_cmd(10'd0, 10'd319, 10'd0, 10'd239, 12'h0FF);
        wait_done("full_done", 80000);
        chk("full_count", beats.size(), 76800);
        if (beats.size() == 76800) begin
            chk("full_last", beats[76799], 76799);
            chk("full_row_end", beats[319], 319);
            chk("full_row_start", beats[320], 320);
        end
        bad = 0;
        foreach (beats[i]) if (beats[i] !== 18'(i)) bad++;
        chk("full_order", bad, 0);
        chk("full_done_cyc", done_cyc - acc_cyc, 76801);
        chk("full_err", done_err, 0);

        // abort during a stalled fifth beat
        stall_from = 5; stall_len = 3; abort_en = 1'b1; abort_at = 6;
        start_cmd(10'd0, 10'd9, 10'd0, 10'd9, 12'h321);
        wait_done("abort_done", 40);
        chk("abort_count", beats.size(), 5);
        if (beats.size() == 5) chk("abort_last", beats[4], 4);
        chk("abort_done_cyc", done_cyc - acc_cyc, 9);
        chk("abort_err", done_err, 1);

        // asynchronous reset mid-fill
        start_cmd(10'd0, 10'd9, 10'd0, 10'd9, 12'h777);
        repeat (3) @(posedge sys_clk);
        #4;
        chk("rstmid_write_before", avn_write, 1);
        sys_rst_n = 1'b0;
        #1;
        chk("rstmid_write", avn_write, 0);
        chk("rstmid_ready", cmd_ready, 1);
        chk("rstmid_busy", busy, 0);
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rstmid_no_done", done_cnt, 0);
        acc_seen = 1'b0;
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;

        // recovery after reset
        start_cmd(10'd1, 10'd1, 10'd1, 10'd1, 12'h00F);
        wait_done("recov_done", 20);
        chk("recov_count", beats.size(), 1);
        if (beats.size() == 1) chk("recov_addr", beats[0], 321);
        chk("recov_done_cyc", done_cyc - acc_cyc, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
